mod_updown_counter: RTL and testbench

Parametrised modulo-N up/down counter with synchronous load, wrap or saturate mode, and same-cycle carry/borrow strobes for cascading. It generalises the clock's single-direction overflow counter so one block serves seconds/minutes/hours chains and the set-time path, where the user steps digits both up and down and loads preset values. Chained instances form a ripple of enables: one stage's `o_carry`/`o_borrow` drives the next stage's `i_en`.

---
 rtl/mod_updown_counter.sv | 71 +++++++
 tb/tb_mod_updown_counter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with clamped synchronous load and wrap/saturate bounds; count latency 1 cycle.
// Carry/borrow strobes are combinational for zero-latency cascading; no backpressure, enable steps every cycle.
module mod_updown_counter #(
    parameter int WIDTH       = 8,
    parameter int MODULUS     = 60,
    parameter int RESET_VALUE = 0,
    parameter int SATURATE    = 0
) (
    input  logic             i_sysclk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_count,
    output logic             o_carry,
    output logic             o_borrow,
    output logic             o_at_max,
    output logic             o_at_min
);

    // MODULUS-1 truncated to WIDTH so MODULUS = 2^WIDTH rolls over naturally.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] MIN_VAL = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;
    logic             at_min;
    logic             step_ok;

    assign at_max  = (count_q == MAX_VAL);
    assign at_min  = (count_q == MIN_VAL);
    assign step_ok = i_en & ~i_load & ~i_reset;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            // Out-of-range loads clamp so the register never leaves 0..MODULUS-1.
            count_d = (i_load_value > MAX_VAL) ? MAX_VAL : i_load_value;
        end else if (i_en) begin
            if (!i_dir) begin
                if (!at_max)
                    count_d = count_q + ONE;
                else if (SATURATE == 0)
                    count_d = MIN_VAL;
            end else begin
                if (!at_min)
                    count_d = count_q - ONE;
                else if (SATURATE == 0)
                    count_d = MAX_VAL;
            end
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_reset)
            count_q <= RST_VAL;
        else
            count_q <= count_d;
    end

    assign o_count  = count_q;
    assign o_at_max = at_max;
    assign o_at_min = at_min;
    assign o_carry  = step_ok & ~i_dir & at_max;
    assign o_borrow = step_ok &  i_dir & at_min;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboarded random and directed bench for mod_updown_counter, including two-stage cascades.
// Expected values come from integer modular arithmetic on an abstract count.
module tb_mod_updown_counter;

    typedef struct {
        int cnt;
        bit carry;
        bit borrow;
        bit amax;
        bit amin;
    } exp_t;

    typedef struct {
        int s1;
        int s2;
        bit c1;
        bit c2;
    } cexp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld = 1'b0;
    logic [7:0] lv = 8'd0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       casc_en = 1'b0;

    logic [7:0] a_count, b_count, c1_count, c2_count, d1_count, d2_count;
    logic a_carry, a_borrow, a_max, a_min;
    logic b_carry, b_borrow, b_max, b_min;
    logic c1_carry, c1_borrow, c1_max, c1_min, c2_carry, c2_borrow, c2_max, c2_min;
    logic d1_carry, d1_borrow, d1_max, d1_min, d2_carry, d2_borrow, d2_max, d2_min;

    always #5 clk = ~clk;

    // A: wrap, MODULUS 60, reset value 5
    mod_updown_counter #(.WIDTH(8), .MODULUS(60), .RESET_VALUE(5), .SATURATE(0)) u_a (
        .i_sysclk(clk), .i_reset(rst), .i_en(en), .i_dir(dir), .i_load(ld), .i_load_value(lv),
        .o_count(a_count), .o_carry(a_carry), .o_borrow(a_borrow), .o_at_max(a_max), .o_at_min(a_min));

    // B: saturate, MODULUS 24
    mod_updown_counter #(.WIDTH(8), .MODULUS(24), .RESET_VALUE(0), .SATURATE(1)) u_b (
        .i_sysclk(clk), .i_reset(rst), .i_en(en), .i_dir(dir), .i_load(ld), .i_load_value(lv),
        .o_count(b_count), .o_carry(b_carry), .o_borrow(b_borrow), .o_at_max(b_max), .o_at_min(b_min));

    mod_updown_counter #(.WIDTH(8), .MODULUS(60), .RESET_VALUE(0), .SATURATE(0)) u_c1 (
        .i_sysclk(clk), .i_reset(rst), .i_en(casc_en), .i_dir(1'b0), .i_load(1'b0), .i_load_value(8'd0),
        .o_count(c1_count), .o_carry(c1_carry), .o_borrow(c1_borrow), .o_at_max(c1_max), .o_at_min(c1_min));

    mod_updown_counter #(.WIDTH(8), .MODULUS(60), .RESET_VALUE(0), .SATURATE(0)) u_c2 (
        .i_sysclk(clk), .i_reset(rst), .i_en(c1_carry), .i_dir(1'b0), .i_load(1'b0), .i_load_value(8'd0),
        .o_count(c2_count), .o_carry(c2_carry), .o_borrow(c2_borrow), .o_at_max(c2_max), .o_at_min(c2_min));

    mod_updown_counter #(.WIDTH(8), .MODULUS(256), .RESET_VALUE(0), .SATURATE(0)) u_d1 (
        .i_sysclk(clk), .i_reset(rst), .i_en(casc_en), .i_dir(1'b0), .i_load(1'b0), .i_load_value(8'd0),
        .o_count(d1_count), .o_carry(d1_carry), .o_borrow(d1_borrow), .o_at_max(d1_max), .o_at_min(d1_min));

    mod_updown_counter #(.WIDTH(8), .MODULUS(256), .RESET_VALUE(0), .SATURATE(0)) u_d2 (
        .i_sysclk(clk), .i_reset(rst), .i_en(d1_carry), .i_dir(1'b0), .i_load(1'b0), .i_load_value(8'd0),
        .o_count(d2_count), .o_carry(d2_carry), .o_borrow(d2_borrow), .o_at_max(d2_max), .o_at_min(d2_min));

    exp_t  qa[$];
    exp_t  qb[$];
    cexp_t qc[$];
    cexp_t qd[$];

    int n_chk  = 0;
    int n_fail = 0;
    int c2_fires = 0;
    int ma, mb, nc;
    bit casc_phase = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic exp_t observe(input int m, input int cnt, input bit r, input bit l,
                                     input bit e, input bit d);
        exp_t x;
        x.cnt    = cnt;
        x.amax   = (cnt == m - 1);
        x.amin   = (cnt == 0);
        x.carry  = e && !d && !l && !r && (cnt == m - 1);
        x.borrow = e &&  d && !l && !r && (cnt == 0);
        return x;
    endfunction

    function automatic int next_cnt(input int m, input bit sat, input int rv, input int cnt,
                                    input bit r, input bit l, input int lval, input bit e, input bit d);
        if (r) return rv;
        if (l) return (lval < m) ? lval : m - 1;
        if (!e) return cnt;
        if (!d) return sat ? ((cnt + 1 > m - 1) ? m - 1 : cnt + 1) : (cnt + 1) % m;
        return sat ? ((cnt - 1 < 0) ? 0 : cnt - 1) : (cnt - 1 + m) % m;
    endfunction

    function automatic cexp_t casc_obs(input int m, input int n, input bit e, input bit r);
        cexp_t x;
        x.s1 = n % m;
        x.s2 = (n / m) % m;
        x.c1 = e && !r && (x.s1 == m - 1);
        x.c2 = x.c1 && (x.s2 == m - 1);
        return x;
    endfunction

    // Drive one cycle of inputs shortly after the edge and queue what the outputs must show.
    task automatic cyc(input bit r, input bit l, input int lval, input bit e, input bit d, input bit ce);
        @(posedge clk);
        #1;
        rst = r; ld = l; lv = 8'(lval); en = e; dir = d; casc_en = ce;
        qa.push_back(observe(60, ma, r, l, e, d));
        qb.push_back(observe(24, mb, r, l, e, d));
        qc.push_back(casc_obs(60, nc, ce, r));
        qd.push_back(casc_obs(256, nc, ce, r));
        ma = next_cnt(60, 1'b0, 5, ma, r, l, lval, e, d);
        mb = next_cnt(24, 1'b1, 0, mb, r, l, lval, e, d);
        nc = r ? 0 : (ce ? nc + 1 : nc);
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0) begin
            exp_t xa, xb;
            cexp_t xc, xd;
            xa = qa.pop_front();
            xb = qb.pop_front();
            xc = qc.pop_front();
            xd = qd.pop_front();
            chk("a_count",  int'(a_count),  xa.cnt);
            chk("a_carry",  int'(a_carry),  int'(xa.carry));
            chk("a_borrow", int'(a_borrow), int'(xa.borrow));
            chk("a_at_max", int'(a_max),    int'(xa.amax));
            chk("a_at_min", int'(a_min),    int'(xa.amin));
            chk("b_count",  int'(b_count),  xb.cnt);
            chk("b_carry",  int'(b_carry),  int'(xb.carry));
            chk("b_borrow", int'(b_borrow), int'(xb.borrow));
            chk("b_at_max", int'(b_max),    int'(xb.amax));
            chk("b_at_min", int'(b_min),    int'(xb.amin));
            if (casc_phase) begin
                chk("c1_count", int'(c1_count), xc.s1);
                chk("c2_count", int'(c2_count), xc.s2);
                chk("c1_carry", int'(c1_carry), int'(xc.c1));
                chk("c2_carry", int'(c2_carry), int'(xc.c2));
                chk("d1_count", int'(d1_count), xd.s1);
                chk("d2_count", int'(d2_count), xd.s2);
                chk("d1_carry", int'(d1_carry), int'(xd.c1));
                chk("d2_carry", int'(d2_carry), int'(xd.c2));
                if (c2_carry) c2_fires++;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        ma = 5; mb = 0; nc = 0;

        // reset state visible, then load 0 and step up through a full wrap
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) cyc(0, 0, 0, 1, 0, 0);
        // down-wrap from 0, then observe at_max
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // load beats enable, with clamp; then in-range load
        cyc(0, 1, 75, 1, 0, 0);
        cyc(0, 1, 12, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // saturate bounds on B
        cyc(0, 1, 23, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        // reset wins over load and enable at the top of the range
        cyc(0, 1, 59, 0, 0, 0);
        cyc(1, 1, 30, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // exact-boundary loads
        cyc(0, 1, 59, 0, 0, 0);
        cyc(0, 1, 60, 0, 0, 0);
        cyc(0, 1, 255, 0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            bit r, l, e, d;
            int v;
            r = ($urandom_range(0, 63) == 0);
            l = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 1) == 1);
            v = $urandom_range(0, 255);
            cyc(r, l, v, e, d, 0);
        end

        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        casc_phase = 1'b1;
        for (int i = 0; i < 3600; i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("c1_final", int'(c1_count), 0);
        chk("c2_final", int'(c2_count), 0);
        chk("c2_fire_count", c2_fires, 1);
        chk("queue_drained", qa.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
